// File: rtl/sand_pkg.sv
// Shared types for the falling-sand physics stage: scan FSM states and cell encoding.
package sand_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_CUR  = 4'd1,
    S_CHK_CUR = 4'd2,
    S_RD_B    = 4'd3,
    S_CHK_B   = 4'd4,
    S_RD_D1   = 4'd5,
    S_CHK_D1  = 4'd6,
    S_RD_D2   = 4'd7,
    S_CHK_D2  = 4'd8,
    S_WR_CLR  = 4'd9,
    S_WR_SET  = 4'd10,
    S_NEXT    = 4'd11,
    S_DONE    = 4'd12
  } sand_state_t;

  localparam logic CELL_EMPTY = 1'b0;
  localparam logic CELL_SAND  = 1'b1;

endpackage

// File: rtl/sand_scan_counter.sv
// Cell walker for the bottom-up scan: x runs left to right, y runs from the second-to-last row up to 0.
// The row base address tracks y*ACTIVE_COLUMNS incrementally so no multiplier is needed.
module sand_scan_counter #(
  parameter int ADDR_WIDTH     = 19,
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int XW             = $clog2(ACTIVE_COLUMNS),
  parameter int YW             = $clog2(ACTIVE_ROWS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init,
  input  logic                  step,
  output logic [XW-1:0]         x,
  output logic [ADDR_WIDTH-1:0] row_base,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] step_addr
);

  localparam logic [XW-1:0]         X_LAST     = XW'(ACTIVE_COLUMNS - 1);
  localparam logic [YW-1:0]         Y_FIRST    = YW'(ACTIVE_ROWS - 2);
  localparam logic [ADDR_WIDTH-1:0] BASE_FIRST = ADDR_WIDTH'((ACTIVE_ROWS - 2) * ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(ACTIVE_COLUMNS);

  logic [XW-1:0]         x_r;
  logic [YW-1:0]         y_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic                  wrap_s;
  logic [XW-1:0]         x_next_s;
  logic [YW-1:0]         y_next_s;
  logic [ADDR_WIDTH-1:0] base_next_s;

  // Position the walker will occupy after one step.
  always_comb begin
    wrap_s      = (x_r == X_LAST);
    x_next_s    = x_r + XW'(1);
    y_next_s    = y_r;
    base_next_s = base_r;
    if (wrap_s) begin
      x_next_s    = {XW{1'b0}};
      y_next_s    = y_r - YW'(1);
      base_next_s = base_r - ROW_STRIDE;
    end else begin
      x_next_s    = x_r + XW'(1);
      y_next_s    = y_r;
      base_next_s = base_r;
    end
  end

  // Counter registers: start of scan, single step, or hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_r    <= {XW{1'b0}};
      y_r    <= {YW{1'b0}};
      base_r <= {ADDR_WIDTH{1'b0}};
    end else if (init) begin
      x_r    <= {XW{1'b0}};
      y_r    <= Y_FIRST;
      base_r <= BASE_FIRST;
    end else if (step) begin
      x_r    <= x_next_s;
      y_r    <= y_next_s;
      base_r <= base_next_s;
    end else begin
      x_r    <= x_r;
      y_r    <= y_r;
      base_r <= base_r;
    end
  end

  assign x         = x_r;
  assign row_base  = base_r;
  assign last      = (y_r == {YW{1'b0}}) && wrap_s;
  assign step_addr = base_next_s + ADDR_WIDTH'(x_next_s);

endmodule

// File: rtl/sand_update_engine.sv
// Falling-sand physics stage: one bottom-up pass over the game RAM per start pulse,
// moving each grain down or diagonally, with every RAM write mirrored to the VRAM port.
module sand_update_engine
  import sand_pkg::*;
#(
  parameter int ADDR_WIDTH     = 19,
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic                              spawn_valid_i,
  input  logic [$clog2(ACTIVE_COLUMNS)-1:0] spawn_x_i,
  output logic                              spawn_ready_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [ADDR_WIDTH-1:0]             game_read_addr_o,
  input  logic                              game_read_data_i,
  output logic                              game_write_en_o,
  output logic [ADDR_WIDTH-1:0]             game_write_addr_o,
  output logic                              game_write_data_o,
  output logic                              vram_write_en_o,
  output logic [ADDR_WIDTH-1:0]             vram_write_addr_o,
  output logic                              vram_write_data_o
);

  localparam int XW = $clog2(ACTIVE_COLUMNS);
  localparam logic [XW-1:0]         X_LAST     = XW'(ACTIVE_COLUMNS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'((ACTIVE_ROWS - 2) * ACTIVE_COLUMNS);

  sand_state_t           state_r;
  logic                  parity_r;
  logic                  busy_r;
  logic                  done_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic                  wr_data_r;
  logic [ADDR_WIDTH-1:0] dst_r;

  logic [XW-1:0]         x_s;
  logic [ADDR_WIDTH-1:0] row_base_s;
  logic                  last_s;
  logic [ADDR_WIDTH-1:0] step_addr_s;
  logic                  init_s;
  logic                  step_s;
  logic [ADDR_WIDTH-1:0] cur_addr_s;
  logic [ADDR_WIDTH-1:0] below_s;
  logic                  left_ok_s;
  logic                  right_ok_s;
  logic [ADDR_WIDTH-1:0] d1_addr_s;
  logic [ADDR_WIDTH-1:0] d2_addr_s;
  logic                  d1_ok_s;
  logic                  d2_ok_s;
  logic                  read_empty_s;

  assign init_s = (state_r == S_IDLE) && start_i;
  assign step_s = (state_r == S_NEXT) && !last_s;

  sand_scan_counter #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .ACTIVE_COLUMNS (ACTIVE_COLUMNS),
    .ACTIVE_ROWS    (ACTIVE_ROWS)
  ) u_scan_counter (
    .clk       (clk_i),
    .reset_n   (reset_i),
    .init      (init_s),
    .step      (step_s),
    .x         (x_s),
    .row_base  (row_base_s),
    .last      (last_s),
    .step_addr (step_addr_s)
  );

  // Neighbour addresses; diagonal preference alternates every frame to avoid a sideways drift.
  always_comb begin
    cur_addr_s = row_base_s + ADDR_WIDTH'(x_s);
    below_s    = cur_addr_s + ROW_STRIDE;
    left_ok_s  = (x_s != {XW{1'b0}});
    right_ok_s = (x_s != X_LAST);
    if (parity_r) begin
      d1_addr_s = below_s + ADDR_WIDTH'(1);
      d1_ok_s   = right_ok_s;
      d2_addr_s = below_s - ADDR_WIDTH'(1);
      d2_ok_s   = left_ok_s;
    end else begin
      d1_addr_s = below_s - ADDR_WIDTH'(1);
      d1_ok_s   = left_ok_s;
      d2_addr_s = below_s + ADDR_WIDTH'(1);
      d2_ok_s   = right_ok_s;
    end
  end

  assign read_empty_s = (game_read_data_i == CELL_EMPTY);

  // Scan FSM with registered RAM/VRAM strobes, busy and done.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r   <= S_IDLE;
      parity_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_data_r <= 1'b0;
      dst_r     <= {ADDR_WIDTH{1'b0}};
    end else begin
      wr_en_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            busy_r    <= 1'b1;
            rd_addr_r <= FIRST_ADDR;
            state_r   <= S_RD_CUR;
          end else if (spawn_valid_i) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= ADDR_WIDTH'(spawn_x_i);
            wr_data_r <= CELL_SAND;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RD_CUR: state_r <= S_CHK_CUR;
        S_CHK_CUR: begin
          if (read_empty_s) begin
            state_r <= S_NEXT;
          end else begin
            rd_addr_r <= below_s;
            state_r   <= S_RD_B;
          end
        end
        S_RD_B: state_r <= S_CHK_B;
        S_CHK_B: begin
          if (read_empty_s) begin
            dst_r     <= below_s;
            wr_en_r   <= 1'b1;
            wr_addr_r <= cur_addr_s;
            wr_data_r <= CELL_EMPTY;
            state_r   <= S_WR_CLR;
          end else if (d1_ok_s) begin
            rd_addr_r <= d1_addr_s;
            state_r   <= S_RD_D1;
          end else if (d2_ok_s) begin
            rd_addr_r <= d2_addr_s;
            state_r   <= S_RD_D2;
          end else begin
            state_r <= S_NEXT;
          end
        end
        S_RD_D1: state_r <= S_CHK_D1;
        S_CHK_D1: begin
          if (read_empty_s) begin
            dst_r     <= d1_addr_s;
            wr_en_r   <= 1'b1;
            wr_addr_r <= cur_addr_s;
            wr_data_r <= CELL_EMPTY;
            state_r   <= S_WR_CLR;
          end else if (d2_ok_s) begin
            rd_addr_r <= d2_addr_s;
            state_r   <= S_RD_D2;
          end else begin
            state_r <= S_NEXT;
          end
        end
        S_RD_D2: state_r <= S_CHK_D2;
        S_CHK_D2: begin
          if (read_empty_s) begin
            dst_r     <= d2_addr_s;
            wr_en_r   <= 1'b1;
            wr_addr_r <= cur_addr_s;
            wr_data_r <= CELL_EMPTY;
            state_r   <= S_WR_CLR;
          end else begin
            state_r <= S_NEXT;
          end
        end
        S_WR_CLR: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= dst_r;
          wr_data_r <= CELL_SAND;
          state_r   <= S_WR_SET;
        end
        S_WR_SET: state_r <= S_NEXT;
        S_NEXT: begin
          if (last_s) begin
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            rd_addr_r <= step_addr_s;
            state_r   <= S_RD_CUR;
          end
        end
        S_DONE: begin
          busy_r   <= 1'b0;
          parity_r <= ~parity_r;
          state_r  <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign spawn_ready_o     = reset_i && (state_r == S_IDLE) && !start_i;
  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign game_read_addr_o  = rd_addr_r;
  assign game_write_en_o   = wr_en_r;
  assign game_write_addr_o = wr_addr_r;
  assign game_write_data_o = wr_data_r;
  assign vram_write_en_o   = wr_en_r;
  assign vram_write_addr_o = wr_addr_r;
  assign vram_write_data_o = wr_data_r;

endmodule
